aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Control sequencer for the AES-128 encryption datapath. Accepts a start request and then steps through the full round schedule: state load, initial AddRoundKey, rounds 1–10, done. Each cycle it drives one datapath operation code, the current round index and the key-expansion strobe. It sits between the top-level host/SPI interface and the shared round datapath and key-expansion unit, and is their only source of control.

## Interface
Parameters:
- NROUNDS, default 10: number of cipher rounds. Only 10 (AES-128) is supported; other values are out of scope.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  start request; sampled only in IDLE
- sbox_valid  input  1  S-box result ready; used only when AES_SBOX_WAIT_EN is defined
- operation  output  4  datapath op code: 0 NOP, 1 LOAD_STATE, 2 ADD_ROUND_KEY, 3 SUB_BYTES, 4 SHIFT_ROWS, 5 MIX_COLUMNS; codes 6–15 are never driven
- round  output  4  current round index, 0–10
- key_update  output  1  high for one cycle: key unit computes the round key for `round` from the previous key
- busy  output  1  high from LOAD through the final ADD_ROUND_KEY
- done  output  1  single-cycle pulse after the final round

## Operation
- Moore FSM. All outputs are registered and decoded from the state and the round counter.
- States and outputs:
  - IDLE: op=NOP, busy=0
  - LOAD: op=LOAD_STATE, round=0
  - INIT_ARK: op=ADD_ROUND_KEY, round=0
  - KEY: op=NOP, key_update=1
  - SUB: op=SUB_BYTES
  - SHIFT: op=SHIFT_ROWS
  - MIX: op=MIX_COLUMNS
  - ARK: op=ADD_ROUND_KEY
  - DONE: op=NOP, done=1, busy=0
- Transitions:
  - IDLE→LOAD when load=1.
  - LOAD→INIT_ARK→KEY. The round counter becomes 1 on entry to KEY.
  - KEY→SUB→SHIFT.
  - SHIFT→MIX when round<10; SHIFT→ARK when round=10. Round 10 has no MixColumns.
  - MIX→ARK.
  - ARK→KEY with round+1 when round<10; ARK→DONE when round=10.
  - DONE→IDLE unconditionally.
- Round counter: 4-bit, never exceeds 10. It holds its value in DONE and clears to 0 on entry to IDLE or LOAD.
- load is ignored in every state except IDLE, including DONE. There is no queued start; the host re-asserts load in IDLE.
- load held high continuously restarts the sequence every time the FSM passes through IDLE.
- Reset at any cycle forces IDLE on the next edge, regardless of state or sbox_valid.
- Reset values: operation=0, round=0, key_update=0, busy=0, done=0.

## Timing
- Edge 0: load=1 sampled in IDLE.
- Cycle 1: LOAD.
- Cycle 2: INIT_ARK.
- Rounds r=1..9: KEY/SUB/SHIFT/MIX/ARK occupy cycles 3+5(r−1) through 7+5(r−1).
- Round 10: KEY=48, SUB=49, SHIFT=50, ARK=51.
- DONE: cycle 52. IDLE: cycle 53.
- Without wait states, load-accept to done pulse is 52 cycles, and done is high for exactly 1 cycle.
- key_update asserts exactly 10 times per encryption, each time with round=1..10 in order.
- busy is high for cycles 1–51 inclusive.
- Each SUB cycle adds k extra cycles to all later timestamps when AES_SBOX_WAIT_EN is defined and sbox_valid stays low for k cycles.

## Configuration
- AES_SBOX_WAIT_EN defined:
  - SUB holds (operation=SUB_BYTES, round unchanged) until sbox_valid=1 is sampled in SUB, then advances to SHIFT.
  - This supports EBR-based S-boxes with multi-cycle latency.
- AES_SBOX_WAIT_EN undefined:
  - SUB lasts exactly one cycle.
  - sbox_valid is ignored but the port remains present.

## Test plan
- Reset then one load pulse (macro off): operation sequence matches the Timing section cycle-for-cycle; done=1 only at cycle 52; round=10 in cycles 48–51.
- Count key_update over one encryption: exactly 10 pulses with round values 1,2,…,10; MIX_COLUMNS appears exactly 9 times; ADD_ROUND_KEY appears 11 times.
- load pulsed at cycles 10 and 52 (DONE): both ignored; no restart; FSM reaches IDLE at 53; load at cycle 55 starts a new run with done at cycle 55+52.
- reset asserted at cycle 30 (mid-round 6): next cycle all outputs at reset values and state IDLE; a following load gives a full 52-cycle run from round 0.
- Macro on, sbox_valid low for 3 cycles in round-1 SUB only: SUB_BYTES held for 4 cycles at round=1; done at cycle 55.
- Macro on, sbox_valid tied 1: timing identical to macro off (done at cycle 52).

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the AES-128 round datapath and key-expansion unit.
// Optional feature macro: AES_SBOX_WAIT_EN (SUB holds until sbox_valid is sampled high).
module aes_round_sequencer #(
  parameter int NROUNDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       sbox_valid,
  output logic [3:0] operation,
  output logic [3:0] round,
  output logic       key_update,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT_ARK,
    S_KEY,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_ARK,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_LOAD_STATE = 4'd1;
  localparam logic [3:0] OP_ADD_RK     = 4'd2;
  localparam logic [3:0] OP_SUB_BYTES  = 4'd3;
  localparam logic [3:0] OP_SHIFT_ROWS = 4'd4;
  localparam logic [3:0] OP_MIX_COLS   = 4'd5;
  localparam logic [3:0] LAST_ROUND    = 4'(NROUNDS);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] op_q, op_d;
  logic       key_update_q, key_update_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

`ifndef AES_SBOX_WAIT_EN
  logic unused_sbox_valid;
  assign unused_sbox_valid = sbox_valid;
`endif

  // Next state and round counter; the counter only moves on entry to KEY or IDLE/LOAD.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        round_d = 4'd0;
        if (load) state_d = S_LOAD;
      end
      S_LOAD: begin
        round_d = 4'd0;
        state_d = S_INIT_ARK;
      end
      S_INIT_ARK: begin
        round_d = 4'd1;
        state_d = S_KEY;
      end
      S_KEY: state_d = S_SUB;
      S_SUB: begin
`ifdef AES_SBOX_WAIT_EN
        if (sbox_valid) state_d = S_SHIFT;
`else
        state_d = S_SHIFT;
`endif
      end
      S_SHIFT: state_d = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
      S_MIX:   state_d = S_ARK;
      S_ARK: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          state_d = S_KEY;
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered with it.
  always_comb begin
    op_d         = OP_NOP;
    key_update_d = 1'b0;
    busy_d       = 1'b1;
    done_d       = 1'b0;
    unique case (state_d)
      S_IDLE:     busy_d = 1'b0;
      S_LOAD:     op_d = OP_LOAD_STATE;
      S_INIT_ARK: op_d = OP_ADD_RK;
      S_KEY:      key_update_d = 1'b1;
      S_SUB:      op_d = OP_SUB_BYTES;
      S_SHIFT:    op_d = OP_SHIFT_ROWS;
      S_MIX:      op_d = OP_MIX_COLS;
      S_ARK:      op_d = OP_ADD_RK;
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default:    busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      round_q      <= 4'd0;
      op_q         <= OP_NOP;
      key_update_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      op_q         <= op_d;
      key_update_q <= key_update_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign operation  = op_q;
  assign round      = round_q;
  assign key_update = key_update_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer against a schedule-list model of one encryption.
// Builds with or without AES_SBOX_WAIT_EN; the model follows the same macro.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       sbox_valid = 1'b0;
  logic [3:0] operation;
  logic [3:0] round;
  logic       key_update;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rnd;
    logic       ku;
    logic       bsy;
    logic       dn;
  } expT;

  expT sched[$];
  int  kuCount, kuOrderErr, mixCount, arkCount, lastDoneCycle;

  aes_round_sequencer #(.NROUNDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .sbox_valid(sbox_valid),
    .operation (operation),
    .round     (round),
    .key_update(key_update),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic expT mk(input int op, input int r, input bit ku, input bit b, input bit d);
    expT e;
    e.op  = op[3:0];
    e.rnd = r[3:0];
    e.ku  = ku;
    e.bsy = b;
    e.dn  = d;
    return e;
  endfunction

  // Expected visible cycles after load is accepted, ending with the return to IDLE.
  function automatic void buildRun();
    sched.delete();
    sched.push_back(mk(1, 0, 0, 1, 0));
    sched.push_back(mk(2, 0, 0, 1, 0));
    for (int r = 1; r <= 10; r++) begin
      sched.push_back(mk(0, r, 1, 1, 0));
      sched.push_back(mk(3, r, 0, 1, 0));
      sched.push_back(mk(4, r, 0, 1, 0));
      if (r < 10) sched.push_back(mk(5, r, 0, 1, 0));
      sched.push_back(mk(2, r, 0, 1, 0));
    end
    sched.push_back(mk(0, 10, 0, 0, 1));
    sched.push_back(mk(0, 0, 0, 0, 0));
  endfunction

  // loadMode: 0 random, 1 held high, 2 pulses only at cycles 10 and 52.
  task automatic runSched(input string tag, input int stallFirstSub, input int loadMode, input int stopAt);
    int  idx;
    int  cyc;
    int  stallLeft;
    bit  sv;
    expT obs;
    buildRun();
    idx = 0;
    stallLeft = stallFirstSub;
    kuCount = 0; kuOrderErr = 0; mixCount = 0; arkCount = 0; lastDoneCycle = -1;
    load = 1'b1;
    sbox_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      obs = {operation, round, key_update, busy, done};
      checks++;
      if (obs !== sched[idx]) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got op=%0d round=%0d ku=%b busy=%b done=%b, expected op=%0d round=%0d ku=%b busy=%b done=%b",
                 tag, cyc, obs.op, obs.rnd, obs.ku, obs.bsy, obs.dn,
                 sched[idx].op, sched[idx].rnd, sched[idx].ku, sched[idx].bsy, sched[idx].dn);
      end
      if (key_update) begin
        kuCount++;
        if (round != 4'(kuCount)) kuOrderErr++;
      end
      if (operation == 4'd5) mixCount++;
      if (operation == 4'd2) arkCount++;
      if (done) lastDoneCycle = cyc;
      if (idx == sched.size() - 1) break;
      if (stopAt != 0 && cyc >= stopAt) return;
      if (cyc > 400) begin
        errors++;
        $display("[TB] FAIL %s timeout: cycle %0d, schedule index %0d required %0d", tag, cyc, idx, sched.size() - 1);
        return;
      end
      case (loadMode)
        1:       load = 1'b1;
        2:       load = (cyc == 10 || cyc == 52);
        default: load = 1'($urandom_range(0, 1));
      endcase
      if (sched[idx].op == 4'd3) begin
        if (stallLeft > 0 && sched[idx].rnd == 4'd1) begin
          sv = 1'b0;
          stallLeft--;
        end else begin
          sv = 1'b1;
        end
      end else begin
        sv = 1'($urandom_range(0, 1));
      end
      sbox_valid = sv;
`ifdef AES_SBOX_WAIT_EN
      if (!(sched[idx].op == 4'd3 && !sv)) idx++;
`else
      idx++;
`endif
      @(posedge clk); #1;
      cyc++;
    end
    if (loadMode != 1) load = 1'b0;
  endtask

  task automatic test_reset();
    expT obs;
    reset = 1'b1; load = 1'b1; sbox_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {operation, round, key_update, busy, done};
      checks++;
      if (obs !== 11'd0) begin
        errors++;
        $display("[TB] FAIL reset_state: got %h, expected 000", obs);
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_single_run();
    runSched("single_run", 0, 0, 0);
    checks++;
    if (lastDoneCycle != 52) begin
      errors++;
      $display("[TB] FAIL done_cycle: got %0d, expected 52", lastDoneCycle);
    end
    checks++;
    if (kuCount != 10 || kuOrderErr != 0) begin
      errors++;
      $display("[TB] FAIL key_update_count: got %0d pulses (%0d out of order), expected 10 in order", kuCount, kuOrderErr);
    end
    checks++;
    if (mixCount != 9) begin
      errors++;
      $display("[TB] FAIL mix_count: got %0d, expected 9", mixCount);
    end
    checks++;
    if (arkCount != 11) begin
      errors++;
      $display("[TB] FAIL ark_count: got %0d, expected 11", arkCount);
    end
  endtask

  task automatic test_ignored_load();
    expT obs;
    runSched("ignored_load", 0, 2, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {operation, round, key_update, busy, done};
      checks++;
      if (obs !== 11'd0) begin
        errors++;
        $display("[TB] FAIL idle_hold: got %h, expected 000", obs);
      end
    end
    runSched("restart_run", 0, 0, 0);
    checks++;
    if (lastDoneCycle != 52) begin
      errors++;
      $display("[TB] FAIL restart_done_cycle: got %0d, expected 52", lastDoneCycle);
    end
  endtask

  task automatic test_mid_reset();
    expT obs;
    runSched("pre_reset", 0, 0, 30);
    reset = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    obs = {operation, round, key_update, busy, done};
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %h, expected 000", obs);
    end
    reset = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    runSched("post_reset", 0, 0, 0);
    checks++;
    if (lastDoneCycle != 52) begin
      errors++;
      $display("[TB] FAIL post_reset_done_cycle: got %0d, expected 52", lastDoneCycle);
    end
  endtask

  task automatic test_sbox_stall();
    int expDone;
`ifdef AES_SBOX_WAIT_EN
    expDone = 55;
`else
    expDone = 52;
`endif
    runSched("sbox_stall", 3, 0, 0);
    checks++;
    if (lastDoneCycle != expDone) begin
      errors++;
      $display("[TB] FAIL stall_done_cycle: got %0d, expected %0d", lastDoneCycle, expDone);
    end
  endtask

  task automatic test_back_to_back();
    expT obs;
    for (int i = 0; i < 2; i++) begin
      runSched("back_to_back", 0, 1, 0);
      checks++;
      if (lastDoneCycle != 52) begin
        errors++;
        $display("[TB] FAIL b2b_done_cycle run %0d: got %0d, expected 52", i, lastDoneCycle);
      end
    end
    load = 1'b0;
    @(posedge clk); #1;
    obs = {operation, round, key_update, busy, done};
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got %h, expected 000", obs);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_ignored_load();
    test_mid_reset();
    test_sbox_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
